// File: rtl/ddr5_bank_timer.sv
// ddr5_bank_timer: per-bank DDR5 timing/state tracker producing next-edge may-issue qualifiers
// Ports:
//   clk, rst_n                     - clock (rising edge), synchronous active-low reset
//   cmd_valid_i, cmd_type_i        - command issued to this bank this cycle (0=ACT 1=RD 2=WR 3=PRE)
//   cmd_row_i                      - row address, used by ACT only
//   can_act_o/can_rd_o/can_wr_o/can_pre_o - command legal at the next rising edge
//   row_open_o, open_row_o         - bank ACTIVATING/ACTIVE, row latched by last accepted ACT
//   bank_state_o                   - 0=IDLE 1=ACTIVATING 2=ACTIVE 3=PRECHARGING
//   cmd_err_o                      - sticky illegal-command flag
// Optional feature: define DDR5_BANK_CMD_CHECK_EN to drop illegal commands and flag them on
// cmd_err_o; without it every command is applied unconditionally and cmd_err_o is 0.
module ddr5_bank_timer #(
    parameter int T_RCD   = 76,
    parameter int T_RAS   = 152,
    parameter int T_RC    = 228,
    parameter int T_RP    = 76,
    parameter int T_RTP   = 36,
    parameter int T_WR    = 60,
    parameter int T_CWD   = 76,
    parameter int T_BURST = 16,
    parameter int ROW_W   = 16,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    input  logic [1:0]       cmd_type_i,
    input  logic [ROW_W-1:0] cmd_row_i,
    output logic             can_act_o,
    output logic             can_rd_o,
    output logic             can_wr_o,
    output logic             can_pre_o,
    output logic             row_open_o,
    output logic [ROW_W-1:0] open_row_o,
    output logic [1:0]       bank_state_o,
    output logic             cmd_err_o
);
    localparam int CW = CNT_W + 1;
    localparam logic [CNT_W-1:0] SAT = '1;
    localparam logic [CW-1:0] LIM_RCD = CW'(T_RCD);
    localparam logic [CW-1:0] LIM_RAS = CW'(T_RAS);
    localparam logic [CW-1:0] LIM_RC  = CW'(T_RC);
    localparam logic [CW-1:0] LIM_RP  = CW'(T_RP);
    localparam logic [CW-1:0] LIM_RTP = CW'(T_RTP);
    localparam logic [CW-1:0] LIM_WRR = CW'(T_CWD + T_BURST + T_WR);
    localparam logic [1:0] CMD_ACT = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_WR  = 2'd2;
    localparam logic [1:0] CMD_PRE = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVATING = 2'd1, ACTIVE = 2'd2, PRECHARGING = 2'd3} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_act_q, cnt_act_d, cnt_rd_q, cnt_rd_d;
    logic [CNT_W-1:0] cnt_wr_q, cnt_wr_d, cnt_pre_q, cnt_pre_d;
    logic [ROW_W-1:0] open_row_q, open_row_d;
    logic             acc;

    // Counters hold "clocks elapsed at the next edge": loading 1 on the command edge lets a
    // dependent command fire exactly T edges later with a plain >= compare.
    function automatic logic [CNT_W-1:0] advance(input logic hit, input logic [CNT_W-1:0] cnt);
        return hit ? CNT_W'(1) : (cnt == SAT ? cnt : cnt + 1'b1);
    endfunction

    function automatic logic reached(input logic [CNT_W-1:0] cnt, input logic [CW-1:0] lim);
        return {1'b0, cnt} >= lim;
    endfunction

    assign can_act_o    = state_q == IDLE && reached(cnt_act_q, LIM_RC) && reached(cnt_pre_q, LIM_RP);
    assign can_rd_o     = state_q == ACTIVE;
    assign can_wr_o     = state_q == ACTIVE;
    assign can_pre_o    = state_q == ACTIVE && reached(cnt_act_q, LIM_RAS) &&
                          reached(cnt_rd_q, LIM_RTP) && reached(cnt_wr_q, LIM_WRR);
    assign row_open_o   = state_q == ACTIVATING || state_q == ACTIVE;
    assign open_row_o   = open_row_q;
    assign bank_state_o = state_q;

`ifdef DDR5_BANK_CMD_CHECK_EN
    logic legal, cmd_err_q;
    assign legal = cmd_type_i == CMD_ACT ? can_act_o :
                   cmd_type_i == CMD_RD  ? can_rd_o  :
                   cmd_type_i == CMD_WR  ? can_wr_o  : can_pre_o;
    assign acc = cmd_valid_i && legal;
    assign cmd_err_o = cmd_err_q;
    always_ff @(posedge clk) begin
        cmd_err_q <= !rst_n ? 1'b0 : cmd_err_q | (cmd_valid_i & ~legal);
    end
`else
    assign acc = cmd_valid_i;
    assign cmd_err_o = 1'b0;
`endif

    always_comb begin
        cnt_act_d  = advance(acc && cmd_type_i == CMD_ACT, cnt_act_q);
        cnt_rd_d   = advance(acc && cmd_type_i == CMD_RD, cnt_rd_q);
        cnt_wr_d   = advance(acc && cmd_type_i == CMD_WR, cnt_wr_q);
        cnt_pre_d  = advance(acc && cmd_type_i == CMD_PRE, cnt_pre_q);
        open_row_d = acc && cmd_type_i == CMD_ACT ? cmd_row_i : open_row_q;
        state_d    = state_q;
        // Timed transitions look at the next counter value so the state is already
        // ACTIVE/IDLE in the cycle before the edge where the constraint is met.
        if (state_q == ACTIVATING && reached(cnt_act_d, LIM_RCD)) state_d = ACTIVE;
        if (state_q == PRECHARGING && reached(cnt_pre_d, LIM_RP)) state_d = IDLE;
        if (acc && cmd_type_i == CMD_ACT) state_d = ACTIVATING;
        if (acc && cmd_type_i == CMD_PRE) state_d = PRECHARGING;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_act_q  <= SAT;
            cnt_rd_q   <= SAT;
            cnt_wr_q   <= SAT;
            cnt_pre_q  <= SAT;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_act_q  <= cnt_act_d;
            cnt_rd_q   <= cnt_rd_d;
            cnt_wr_q   <= cnt_wr_d;
            cnt_pre_q  <= cnt_pre_d;
            open_row_q <= open_row_d;
        end
    end
endmodule

// File: tb/tb_ddr5_bank_timer.sv
// tb_ddr5_bank_timer: directed + randomized check of ddr5_bank_timer against a time-stamp model
module tb_ddr5_bank_timer;
    localparam int T_RCD = 76;
    localparam int T_RAS = 152;
    localparam int T_RC  = 228;
    localparam int T_RP  = 76;
    localparam int T_RTP = 36;
    localparam int T_WRR = 76 + 16 + 60;
    localparam int SATV  = 511;
    localparam int NEVER = -1000000;
`ifdef DDR5_BANK_CMD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [15:0] cmd_row = 16'd0;
    logic        can_act, can_rd, can_wr, can_pre, row_open, cmd_err;
    logic [15:0] open_row;
    logic [1:0]  bank_state;

    int n_chk = 0;
    int n_fail = 0;

    // Model: edge index of the last accepted command of each kind, plus bank state.
    int          k = 0;
    int          t_act = NEVER, t_rd = NEVER, t_wr = NEVER, t_pre = NEVER;
    int          st = 0;
    logic [15:0] m_row = 16'd0;
    bit          m_err = 1'b0;
    int          r;

    always #5 clk = ~clk;

    ddr5_bank_timer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
        .cmd_row_i(cmd_row), .can_act_o(can_act), .can_rd_o(can_rd), .can_wr_o(can_wr),
        .can_pre_o(can_pre), .row_open_o(row_open), .open_row_o(open_row),
        .bank_state_o(bank_state), .cmd_err_o(cmd_err)
    );

    // Clocks elapsed since a command, as seen at the upcoming edge, saturating.
    function automatic int el(int t);
        return (k + 1 - t > SATV) ? SATV : k + 1 - t;
    endfunction

    function automatic bit m_act();
        return st == 0 && el(t_act) >= T_RC && el(t_pre) >= T_RP;
    endfunction

    function automatic bit m_rd();
        return st == 2;
    endfunction

    function automatic bit m_pre();
        return st == 2 && el(t_act) >= T_RAS && el(t_rd) >= T_RTP && el(t_wr) >= T_WRR;
    endfunction

    function automatic bit m_legal(logic [1:0] ty);
        return ty == 2'd0 ? m_act() : ty == 2'd3 ? m_pre() : m_rd();
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("can_act", 32'(can_act), 32'(m_act()));
        chk("can_rd", 32'(can_rd), 32'(m_rd()));
        chk("can_wr", 32'(can_wr), 32'(m_rd()));
        chk("can_pre", 32'(can_pre), 32'(m_pre()));
        chk("row_open", 32'(row_open), 32'(st == 1 || st == 2));
        chk("bank_state", 32'(bank_state), 32'(st));
        chk("open_row", 32'(open_row), 32'(m_row));
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
    endtask

    task automatic tick(bit v, logic [1:0] ty, logic [15:0] row);
        bit lg;
        lg = m_legal(ty);
        cmd_valid = v;
        cmd_type = ty;
        cmd_row = row;
        @(posedge clk);
        #1;
        k++;
        if (!rst_n) begin
            t_act = NEVER; t_rd = NEVER; t_wr = NEVER; t_pre = NEVER;
            st = 0; m_row = 16'd0; m_err = 1'b0;
        end else begin
            if (v && (lg || !CHK)) begin
                case (ty)
                    2'd0: begin t_act = k; st = 1; m_row = row; end
                    2'd1: t_rd = k;
                    2'd2: t_wr = k;
                    default: begin t_pre = k; st = 3; end
                endcase
            end else if (v) m_err = 1'b1;
            if (st == 1 && el(t_act) >= T_RCD) st = 2;
            if (st == 3 && el(t_pre) >= T_RP) st = 0;
        end
        cmd_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(int n);
        repeat (n) tick(1'b0, 2'd0, 16'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 2'd0, 16'd0);
        tick(1'b0, 2'd0, 16'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        idle(10);
        chk("rst_can_act", 32'(can_act), 32'd1);
        chk("rst_can_rd", 32'(can_rd), 32'd0);
        chk("rst_can_wr", 32'(can_wr), 32'd0);
        chk("rst_can_pre", 32'(can_pre), 32'd0);
        chk("rst_state", 32'(bank_state), 32'd0);
        chk("rst_open_row", 32'(open_row), 32'd0);

        tick(1'b1, 2'd0, 16'h1234);
        idle(74);
        chk("trcd_early", 32'(can_rd), 32'd0);
        idle(1);
        chk("trcd_ready", 32'(can_rd), 32'd1);
        chk("trcd_state", 32'(bank_state), 32'd2);
        chk("act_row", 32'(open_row), 32'h1234);
        idle(75);
        chk("tras_early", 32'(can_pre), 32'd0);
        idle(1);
        chk("tras_ready", 32'(can_pre), 32'd1);
        tick(1'b1, 2'd3, 16'd0);
        idle(74);
        chk("trc_early", 32'(can_act), 32'd0);
        idle(1);
        chk("trc_ready", 32'(can_act), 32'd1);

        tick(1'b1, 2'd0, 16'h0F0F);
        idle(199);
        tick(1'b1, 2'd2, 16'd0);
        idle(150);
        chk("twr_early", 32'(can_pre), 32'd0);
        idle(1);
        chk("twr_ready", 32'(can_pre), 32'd1);
        idle(48);
        tick(1'b1, 2'd1, 16'd0);
        idle(34);
        chk("trtp_early", 32'(can_pre), 32'd0);
        idle(1);
        chk("trtp_ready", 32'(can_pre), 32'd1);
        tick(1'b1, 2'd3, 16'd0);
        idle(600);
        chk("sat_can_act", 32'(can_act), 32'd1);
        chk("sat_state", 32'(bank_state), 32'd0);

`ifdef DDR5_BANK_CMD_CHECK_EN
        tick(1'b1, 2'd0, 16'hBEEF);
        idle(9);
        tick(1'b1, 2'd1, 16'd0);
        chk("err_set", 32'(cmd_err), 32'd1);
        chk("err_state", 32'(bank_state), 32'd1);
        idle(9);
        rst_n = 1'b0;
        tick(1'b0, 2'd0, 16'd0);
        rst_n = 1'b1;
        chk("err_clear", 32'(cmd_err), 32'd0);
        chk("err_rst_state", 32'(bank_state), 32'd0);
`else
        tick(1'b1, 2'd0, 16'h00AA);
        idle(80);
        tick(1'b1, 2'd0, 16'h0055);
        chk("react_state", 32'(bank_state), 32'd1);
        chk("react_row", 32'(open_row), 32'h0055);
        do_reset();
        tick(1'b1, 2'd3, 16'd0);
        chk("idle_pre_state", 32'(bank_state), 32'd3);
        chk("idle_pre_can_act", 32'(can_act), 32'd0);
`endif
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick(1'b0, 2'd0, 16'd0);
                rst_n = 1'b1;
            end else if (r < 9) tick(1'b0, 2'd0, 16'd0);
            else if (r == 15) tick(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
            else if (m_act()) tick(1'b1, 2'd0, 16'($urandom));
            else if (m_pre() && r < 12) tick(1'b1, 2'd3, 16'd0);
            else if (m_rd() && el(t_act) < 160) tick(1'b1, (r % 2 == 0) ? 2'd1 : 2'd2, 16'd0);
            else tick(1'b0, 2'd0, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
